channel_frame_packer: RTL

- Downstream stage of the per-channel sample counter in the Xike acquisition path.
- Collects one sample per channel, tagged with channel number and last-channel flag, into complete N_CH-sample frames.
- Double-buffers frames in a ping-pong store.
- Emits each frame as an AXI4-Stream packet toward the DMA/spike-detection path, honouring backpressure, flagging sequence errors and counting dropped frames.

---
 rtl/xike_pkg.sv | 27 ++
 rtl/frame_bank_ram.sv | 32 +++
 rtl/channel_frame_packer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/xike_pkg.sv
// ============================================================================
// Package : xike_pkg
// Shared constants and FSM encodings for the Xike frame packer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package xike_pkg;

    localparam int N_CH_DEF   = 16;
    localparam int CH_W_DEF   = 4;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } wr_state_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/frame_bank_ram.sv
// ============================================================================
// Module : frame_bank_ram
// Two-bank sample store, one write port, asynchronous read, addr {bank, idx}.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module frame_bank_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/channel_frame_packer.sv
// ============================================================================
// Module : channel_frame_packer
// Packs per-channel samples into N_CH-word frames, ping-pong buffered, AXIS out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module channel_frame_packer
    import xike_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_CH   = N_CH_DEF,
    parameter int CH_W   = CH_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_last,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [CH_W-1:0]   m_tuser,
    output logic              m_tlast,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt,
    output logic              seq_err
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [1:0]        full;
    logic [1:0]        set_full;
    logic [1:0]        clr_full;

    wr_state_t         wr_state;
    wr_state_t         wr_state_n;
    logic              wr_bank;
    logic              wr_bank_n;
    logic [CH_W-1:0]   wr_idx;
    logic [CH_W-1:0]   wr_idx_n;
    logic [CH_W-1:0]   wr_addr_idx;
    logic              wr_en;
    logic              start;
    logic              drop_inc;
    logic              err_det;
    logic              seq_ok;

    rd_state_t         rd_state;
    logic              rd_bank;
    logic [CH_W-1:0]   rd_idx;
    logic              rd_addr_bank;
    logic [CH_W-1:0]   rd_addr_idx;
    logic [DATA_W-1:0] rd_word;
    logic              hs;
    logic              hs_last;

    // FILL and DROP both track the expected channel so a malformed frame is
    // flagged even while it is being discarded.
    always_comb begin
        seq_ok      = (in_ch == wr_idx) && (in_last == (wr_idx == LAST_CH));
        wr_state_n  = wr_state;
        wr_bank_n   = wr_bank;
        wr_idx_n    = wr_idx;
        wr_addr_idx = wr_idx;
        wr_en       = 1'b0;
        start       = 1'b0;
        drop_inc    = 1'b0;
        err_det     = 1'b0;
        set_full    = 2'b00;
        if (in_valid) begin
            case (wr_state)
                FILL, DROP: begin
                    if (seq_ok) begin
                        wr_en = (wr_state == FILL);
                        if (wr_idx == LAST_CH) begin
                            wr_state_n = SYNC;
                            wr_idx_n   = '0;
                            if (wr_state == FILL) begin
                                set_full[wr_bank] = 1'b1;
                                wr_bank_n         = ~wr_bank;
                            end
                        end else begin
                            wr_idx_n = wr_idx + CH_W'(1);
                        end
                    end else begin
                        err_det    = 1'b1;
                        wr_state_n = SYNC;
                        wr_idx_n   = '0;
                        start      = (in_ch == '0);
                    end
                end
                default: begin
                    wr_state_n = SYNC;
                    start      = (in_ch == '0);
                end
            endcase
            // A channel-0 sample opens a frame, whether from SYNC or after a violation.
            if (start) begin
                wr_addr_idx = '0;
                wr_idx_n    = CH_W'(1);
                if (!full[wr_bank]) begin
                    wr_en      = 1'b1;
                    wr_state_n = FILL;
                end else begin
                    drop_inc   = 1'b1;
                    wr_state_n = DROP;
                end
            end
        end
    end

    always_comb begin
        hs           = m_tvalid && m_tready;
        hs_last      = hs && m_tlast;
        clr_full     = 2'b00;
        if (hs_last) begin
            clr_full[rd_bank] = 1'b1;
        end
        rd_addr_bank = hs_last ? ~rd_bank : rd_bank;
        rd_addr_idx  = ((rd_state == STREAM) && !hs_last) ? rd_idx + CH_W'(1) : '0;
    end

    frame_bank_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (CH_W + 1)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_addr_idx}),
        .wdata (in_data),
        .raddr ({rd_addr_bank, rd_addr_idx}),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= SYNC;
            wr_bank  <= 1'b0;
            wr_idx   <= '0;
            full     <= 2'b00;
            drop_cnt <= '0;
            seq_err  <= 1'b0;
        end else begin
            wr_state <= wr_state_n;
            wr_bank  <= wr_bank_n;
            wr_idx   <= wr_idx_n;
            full     <= (full | set_full) & ~clr_full;
            seq_err  <= err_det;
            if (drop_inc) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign m_tuser = rd_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state  <= IDLE;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tlast   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (rd_state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        rd_state <= STREAM;
                        rd_idx   <= '0;
                        m_tvalid <= 1'b1;
                        m_tdata  <= rd_word;
                        m_tlast  <= (N_CH == 1);
                    end
                end
                STREAM: begin
                    if (hs) begin
                        if (m_tlast) begin
                            rd_bank   <= ~rd_bank;
                            rd_idx    <= '0;
                            frame_cnt <= frame_cnt + 16'd1;
                            // Other bank already waiting: chain without a bubble.
                            if (full[~rd_bank]) begin
                                m_tdata <= rd_word;
                                m_tlast <= (N_CH == 1);
                            end else begin
                                rd_state <= IDLE;
                                m_tvalid <= 1'b0;
                                m_tlast  <= 1'b0;
                            end
                        end else begin
                            rd_idx  <= rd_addr_idx;
                            m_tdata <= rd_word;
                            m_tlast <= (rd_addr_idx == LAST_CH);
                        end
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
